// File: rtl/logic_unit_seq_if.sv
// Handshake bundle for logic_unit_seq.
//   in_valid/in_ready/op/a/b : operation request channel (master -> unit)
//   out_valid/out_ready      : result channel handshake (unit -> master)
//   result/zero/parity       : result payload and flags
interface logic_unit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, parity
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, parity
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit. Accepts two WIDTH-bit operands and an opcode,
// then computes the result SLICE bits per cycle (LSB slice first) and presents
// it with zero/parity flags.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : logic_unit_seq_if.slave (request + result handshakes)
// Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 NAND,
//          110 ANDN (a & ~b), 111 PASSA.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_seq_if.slave      bus
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("logic_unit_seq: WIDTH must be a non-zero multiple of SLICE");
    end
    if ($bits(bus.result) != WIDTH) begin : g_bad_if
      $error("logic_unit_seq: interface WIDTH does not match unit WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q, result_nxt;
  logic [SLICE-1:0]   a_s, b_s, slice_res;
  logic               accept, step, last;

  // Latched operands are shifted right each RUN cycle, so the current
  // slice always sits in the low SLICE bits.
  assign a_s  = a_q[SLICE-1:0];
  assign b_s  = b_q[SLICE-1:0];
  assign last = (cnt == CNT_W'(N - 1));

  always_comb begin
    slice_res = '0;
    case (op_q)
      3'b000:  slice_res = a_s & b_s;
      3'b001:  slice_res = a_s | b_s;
      3'b010:  slice_res = a_s ^ b_s;
      3'b011:  slice_res = ~(a_s | b_s);
      3'b100:  slice_res = ~(a_s ^ b_s);
      3'b101:  slice_res = ~(a_s & b_s);
      3'b110:  slice_res = a_s & ~b_s;
      default: slice_res = a_s;
    endcase
  end

  always_comb begin
    result_nxt = result_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CNT_W'(i)) result_nxt[i*SLICE +: SLICE] = slice_res;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        op_q     <= bus.op;
        cnt      <= '0;
        result_q <= '0;
      end else if (step) begin
        a_q      <= a_q >> SLICE;
        b_q      <= b_q >> SLICE;
        cnt      <= last ? '0 : cnt + 1'b1;
        result_q <= result_nxt;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = ~|result_q;
  assign bus.parity = ^result_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic_unit_seq_if #(.WIDTH(32)) bus32 ();
  logic_unit_seq_if #(.WIDTH(16)) bus16 ();

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  // Present an op and step through the accept edge.
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.in_valid = 1'b1;
    bus32.op = op;
    bus32.a = a;
    bus32.b = b;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid (bounded).
  task automatic wait_out32(output int n);
    n = 0;
    while (!bus32.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain32();
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus32.in_ready); end
    n_checks++; if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus32.out_valid); end
    n_checks++; if (bus32.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus32.result); end
    n_checks++; if (bus32.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", bus32.zero); end
    n_checks++; if (bus32.parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got=%b exp=0", bus32.parity); end
  endtask

  task automatic test_xor();
    int n;
    issue32(3'b010, 32'hFFFF0000, 32'h0F0F0F0F);
    wait_out32(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL xor_latency got=%0d exp=4", n); end
    n_checks++; if (bus32.result !== 32'hF0F00F0F) begin n_fail++; $display("FAIL xor_result got=%h exp=f0f00f0f", bus32.result); end
    n_checks++; if (bus32.zero !== 1'b0) begin n_fail++; $display("FAIL xor_zero got=%b exp=0", bus32.zero); end
    n_checks++; if (bus32.parity !== 1'b0) begin n_fail++; $display("FAIL xor_parity got=%b exp=0", bus32.parity); end
    n_checks++; if (bus32.in_ready !== 1'b0) begin n_fail++; $display("FAIL xor_done_in_ready got=%b exp=0", bus32.in_ready); end
    drain32();
    n_checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_back_idle got in_ready=%b out_valid=%b exp 1/0", bus32.in_ready, bus32.out_valid); end
  endtask

  task automatic test_flags();
    int n;
    issue32(3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
    wait_out32(n);
    n_checks++; if (n !== 4 || bus32.result !== 32'h0) begin n_fail++; $display("FAIL xor_same got lat=%0d res=%h exp 4/0", n, bus32.result); end
    n_checks++; if (bus32.zero !== 1'b1 || bus32.parity !== 1'b0) begin n_fail++; $display("FAIL xor_same_flags got z=%b p=%b exp 1/0", bus32.zero, bus32.parity); end
    drain32();
    issue32(3'b101, 32'hFFFFFFFF, 32'h00000001);
    wait_out32(n);
    n_checks++; if (bus32.result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL nand_result got=%h exp=fffffffe", bus32.result); end
    n_checks++; if (bus32.zero !== 1'b0 || bus32.parity !== 1'b1) begin n_fail++; $display("FAIL nand_flags got z=%b p=%b exp 0/1", bus32.zero, bus32.parity); end
    drain32();
    issue32(3'b110, 32'h000000FF, 32'h0000000F);
    wait_out32(n);
    n_checks++; if (bus32.result !== 32'h000000F0) begin n_fail++; $display("FAIL andn_result got=%h exp=000000f0", bus32.result); end
    drain32();
    issue32(3'b011, 32'h0000FFFF, 32'h00FF0000);
    wait_out32(n);
    n_checks++; if (bus32.result !== 32'hFF000000) begin n_fail++; $display("FAIL nor_result got=%h exp=ff000000", bus32.result); end
    drain32();
    issue32(3'b111, 32'h13572468, 32'hFFFFFFFF);
    wait_out32(n);
    n_checks++; if (bus32.result !== 32'h13572468) begin n_fail++; $display("FAIL passa_result got=%h exp=13572468", bus32.result); end
    drain32();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] held;
    issue32(3'b010, 32'h12345678, 32'hFFFFFFFF);
    wait_out32(n);
    held = bus32.result;
    n_checks++; if (held !== 32'hEDCBA987 || bus32.parity !== 1'b1) begin n_fail++; $display("FAIL bp_result got=%h p=%b exp edcba987/1", held, bus32.parity); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 || bus32.result !== 32'hEDCBA987 || bus32.parity !== 1'b1 || bus32.zero !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b res=%h z=%b p=%b exp 1/0/edcba987/0/1", i, bus32.out_valid, bus32.in_ready, bus32.result, bus32.zero, bus32.parity);
      end
    end
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.op = 3'b001;
    bus32.a = 32'h1;
    bus32.b = 32'h2;
    #1;
    n_checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_both_ready got ir=%b ov=%b exp 1/1", bus32.in_ready, bus32.out_valid); end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b0;
    n_checks++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_run got ov=%b ir=%b exp 0/0", bus32.out_valid, bus32.in_ready); end
    wait_out32(n);
    n_checks++; if (n !== 4 || bus32.result !== 32'h3) begin n_fail++; $display("FAIL b2b_result got lat=%0d res=%h exp 4/00000003", n, bus32.result); end
    drain32();
  endtask

  task automatic test_isolation();
    int n;
    issue32(3'b000, 32'hA5A5A5A5, 32'h0FF00FF0);
    n = 0;
    while (!bus32.out_valid && n < 50) begin
      bus32.a = $urandom;
      bus32.b = $urandom;
      bus32.op = 3'($urandom_range(7, 0));
      @(posedge clk); #1;
      n++;
    end
    n_checks++; if (n !== 4 || bus32.result !== 32'h05A005A0) begin n_fail++; $display("FAIL isolation got lat=%0d res=%h exp 4/05a005a0", n, bus32.result); end
    drain32();
  endtask

  task automatic test_reset_mid_op();
    int n;
    issue32(3'b010, 32'hFFFFFFFF, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (bus32.result === 32'h0) begin n_fail++; $display("FAIL mid_partial got=%h exp nonzero partial", bus32.result); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus32.out_valid !== 1'b0 || bus32.result !== 32'h0 || bus32.zero !== 1'b1) begin n_fail++; $display("FAIL mid_reset got ov=%b res=%h z=%b exp 0/0/1", bus32.out_valid, bus32.result, bus32.zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got ir=%b ov=%b exp 1/0", bus32.in_ready, bus32.out_valid); end
    issue32(3'b100, 32'h0, 32'h0);
    wait_out32(n);
    n_checks++; if (n !== 4 || bus32.result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL xnor_result got lat=%0d res=%h exp 4/ffffffff", n, bus32.result); end
    n_checks++; if (bus32.zero !== 1'b0 || bus32.parity !== 1'b0) begin n_fail++; $display("FAIL xnor_flags got z=%b p=%b exp 0/0", bus32.zero, bus32.parity); end
    drain32();
  endtask

  task automatic test_single_slice();
    int n;
    n_checks++; if (bus16.in_ready !== 1'b1 || bus16.result !== 16'h0 || bus16.zero !== 1'b1) begin n_fail++; $display("FAIL n1_idle got ir=%b res=%h z=%b exp 1/0/1", bus16.in_ready, bus16.result, bus16.zero); end
    bus16.in_valid = 1'b1;
    bus16.op = 3'b000;
    bus16.a = 16'hF0F0;
    bus16.b = 16'hFF00;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL n1_latency got=%0d exp=1", n); end
    n_checks++; if (bus16.result !== 16'hF000 || bus16.zero !== 1'b0 || bus16.parity !== 1'b0) begin n_fail++; $display("FAIL n1_result got res=%h z=%b p=%b exp f000/0/0", bus16.result, bus16.zero, bus16.parity); end
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    n_checks++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL n1_idle_after got ir=%b ov=%b exp 1/0", bus16.in_ready, bus16.out_valid); end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_xor();
    test_flags();
    test_back_to_back();
    test_isolation();
    test_reset_mid_op();
    test_single_slice();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, sequential bitwise logic unit for the ALU datapath: the next generation of the 32-bit combinational XOR array. It accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake and computes the result SLICE bits per cycle, LSB slice first. It returns the result with zero and parity flags over a second valid/ready handshake. It sits between the ALU operand registers and the result writeback mux and replaces per-function gate arrays.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SLICE, otherwise elaboration fails.
- SLICE, 8: bits processed per cycle; N = WIDTH/SLICE cycles per operation (N ≥ 1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 NAND, 110 ANDN (a & ~b), 111 PASSA (a).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream consumes result.
- result  out  WIDTH  bitwise result.
- zero  out  1  result == 0.
- parity  out  1  XOR-reduction of result (1 = odd number of ones).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. If in_valid=1, the unit accepts: it latches a, b and op, clears result, sets the slice counter to 0 and moves to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle computes slice i = counter, writes result[i*SLICE +: SLICE], and increments the counter. After slice N-1 is written it moves to DONE.
- The unit uses only the latched copies of a, b and op. Changes on the a, b and op inputs during RUN/DONE have no effect.
- zero and parity are computed from the full result register and are valid whenever out_valid=1.
- DONE: out_valid=1; result and flags are held stable.
  - out_ready=1: transfer completes at the edge.
  - in_ready = out_ready. If in_valid=1 in the same cycle, the new op is accepted at that edge and the FSM goes directly to RUN (back-to-back). Otherwise it goes to IDLE.
  - out_ready=0: remain in DONE indefinitely; in_ready=0.
- Result bits are not sign- or width-extended; every opcode is defined, so there is no illegal-op path.
- Reset (rst_n=0) at any time, including mid-RUN, takes effect immediately: state=IDLE, counter=0, result=0, out_valid=0. The in-flight operation is discarded.

## Timing
- Reset values:
  - in_ready=1 (IDLE), out_valid=0, result=0.
  - zero=1 (result is 0).
  - parity=0.
- Latency: accept at edge k → out_valid=1 after edge k+N. The result is visible in the cycle following edge k+N.
- Throughput: one operation per N+1 cycles with out_ready held high and back-to-back accept, i.e. N RUN cycles plus 1 DONE cycle.
- N=1 (SLICE=WIDTH): a single RUN cycle; out_valid rises one cycle after accept.
- in_ready and out_valid are never both 1 unless the FSM is in DONE.
- Partial result bits are internal during RUN; the result port shows intermediate slices but out_valid=0, so they are not valid.
- Handshake rules: a transfer occurs only on an edge where valid & ready=1. Valid must not depend combinationally on ready, on either side.

## Test plan
- XOR, WIDTH=32, SLICE=8: a=0xFFFF0000, b=0x0F0F0F0F, accepted at edge k → result=0xF0F00F0F, zero=0, parity=0; out_valid first high after edge k+4.
- Zero/parity: XOR with a=b=0xDEADBEEF → result=0, zero=1, parity=0. NAND with a=0xFFFFFFFF, b=0x00000001 → result=0xFFFFFFFE, parity=1. ANDN with a=0x000000FF, b=0x0000000F → 0x000000F0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready=0. Then raise out_ready with in_valid=1 and a new op (OR 0x1, 0x2) → both transfers at the same edge; the next result is 0x00000003, 4 cycles later.
- Input isolation: change a, b and op every cycle during RUN → the result matches the values latched at accept.
- Reset mid-op: assert rst_n=0 after 2 RUN cycles → out_valid=0, result=0, zero=1 immediately. After release, in_ready=1 and a fresh XNOR of 0x0 with 0x0 → 0xFFFFFFFF.
- Config WIDTH=16, SLICE=16: AND of 0xF0F0 with 0xFF00 → 0xF000; out_valid one cycle after accept.
